// File: rtl/router_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_fifo
// Brief    : Parametrised router output-channel packet FIFO. Each entry holds
//            a header tag bit plus a data byte. The read side tracks the
//            remaining bytes of the packet being drained, pulses pkt_done on
//            the parity byte, and keeps sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int LEN_LSB  = 2,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_en,
  input  logic              read_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       fill_level,
  output logic              pkt_busy,
  output logic              pkt_done,
  output logic              ovf_err,
  output logic              udf_err
);

  // Width of the remaining-byte counter: length field plus one bit for the
  // extra parity byte.
  localparam int          LEN_W   = DATA_W - LEN_LSB;
  localparam int          RW      = LEN_W + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_LEVEL);
  localparam logic [RW-1:0] REM_ONE = {{(RW-1){1'b0}}, 1'b1};

  // Storage: MSB is the header tag, low DATA_W bits the byte.
  logic [DATA_W:0] mem [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              busy_q, busy_d;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W:0]   w_rd_word;
  logic [RW-1:0]     w_hdr_rem;

  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_wr_acc  = write_en && !w_full;
  assign w_rd_acc  = read_en && !w_empty;
  assign w_rd_word = mem[rd_ptr_q[AW-1:0]];
  // Header reload value: payload length plus the trailing parity byte.
  assign w_hdr_rem = {1'b0, w_rd_word[DATA_W-1:LEN_LSB]} + REM_ONE;

  // Next-state computation for pointers, counters, flags and read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    rem_d    = rem_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q | (write_en & w_full);
    udf_d    = udf_q | (read_en & w_empty);

    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (w_rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = w_rd_word[DATA_W-1:0];
      if (w_rd_word[DATA_W]) begin
        // A header always reloads, even if the previous packet was cut short.
        rem_d = w_hdr_rem;
      end else if (rem_q != '0) begin
        rem_d  = rem_q - REM_ONE;
        done_d = (rem_q == REM_ONE);
      end
    end

    case ({w_wr_acc, w_rd_acc})
      2'b10:   fill_d = fill_q + PTR_ONE;
      2'b01:   fill_d = fill_q - PTR_ONE;
      default: fill_d = fill_q;
    endcase

    // Channel timeout flush overrides every other input.
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      rem_d    = '0;
      dout_d   = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    af_d   = (fill_d >= AF_LVL);
    ae_d   = (fill_d <= AE_LVL);
    busy_d = (rem_d != '0);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      rem_q    <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      rem_q    <= rem_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      busy_q   <= busy_d;
    end
  end

  // Storage array write; contents are never reset, and stale entries are
  // unreachable because reads are gated by the pointers.
  always_ff @(posedge clock) begin
    if (w_wr_acc && !soft_reset) begin
      mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out     = dout_q;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fill_level   = fill_q;
  assign pkt_busy     = busy_q;
  assign pkt_done     = done_q;
  assign ovf_err      = ovf_q;
  assign udf_err      = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_fifo
// Brief    : Directed self-checking bench for router_pkt_fifo (DATA_W=8,
//            DEPTH=16) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_fifo;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       empty, full, almost_full, almost_empty;
  logic [4:0] fill_level;
  logic       pkt_busy, pkt_done, ovf_err, udf_err;

  int checks = 0;
  int failures = 0;

  router_pkt_fifo #(
    .DATA_W(8), .DEPTH(16), .LEN_LSB(2), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .soft_reset  (soft_reset),
    .write_en    (write_en),
    .read_en     (read_en),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fill_level  (fill_level),
    .pkt_busy    (pkt_busy),
    .pkt_done    (pkt_done),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic tag);
    write_en = 1'b1; data_in = d; lfd_state = tag;
    tick();
    write_en = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic rd();
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  initial begin
    logic [7:0] pkt [5];
    pkt[0] = 8'h0C; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5E;

    // Reset state
    #12;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_fill", fill_level, 0);
    check("rst_busy", pkt_busy, 0);
    check("rst_done", pkt_done, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_udf", udf_err, 0);
    check("rst_dout", data_out, 0);
    resetn = 1'b1;

    // Single packet: header len=3, three payload bytes, parity
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
    check("pkt_fill", fill_level, 5);
    check("pkt_ae", almost_empty, 0);
    for (int i = 0; i < 5; i++) begin
      rd();
      check("pkt_dout", data_out, pkt[i]);
      check("pkt_done", pkt_done, i == 4);
      check("pkt_busy", pkt_busy, i != 4);
    end
    tick();
    check("pkt_done_pulse", pkt_done, 0);
    check("pkt_empty", empty, 1);

    // Fill to full, watching the almost flags
    for (int i = 0; i < 16; i++) begin
      wr(8'h30 + 8'(i), 1'b0);
      if (i == 1)  check("ae_at2", almost_empty, 1);
      if (i == 2)  check("ae_at3", almost_empty, 0);
      if (i == 12) check("af_at13", almost_full, 0);
      if (i == 13) check("af_at14", almost_full, 1);
    end
    check("full_flag", full, 1);
    check("full_fill", fill_level, 16);
    check("full_ovf0", ovf_err, 0);
    wr(8'hFF, 1'b0);
    check("ovf_set", ovf_err, 1);
    check("ovf_fill", fill_level, 16);

    // Read+write while full: write dropped
    write_en = 1'b1; read_en = 1'b1; data_in = 8'hEE;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    check("rw_full_dout", data_out, 8'h30);
    check("rw_full_fill", fill_level, 15);
    check("rw_full_flag", full, 0);
    for (int i = 1; i < 8; i++) begin
      rd();
      check("drain_a", data_out, 8'h30 + 8'(i));
    end
    check("half_fill", fill_level, 8);

    // Read+write at half: level unchanged
    write_en = 1'b1; read_en = 1'b1; data_in = 8'h77;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    check("rw_half_dout", data_out, 8'h38);
    check("rw_half_fill", fill_level, 8);
    for (int i = 9; i < 16; i++) begin
      rd();
      check("drain_b", data_out, 8'h30 + 8'(i));
    end
    rd();
    check("drain_last", data_out, 8'h77);
    check("drain_empty", empty, 1);
    check("drain_fill", fill_level, 0);
    check("drain_busy", pkt_busy, 0);

    // Underflow: data held, flag sticky
    rd();
    check("udf_dout", data_out, 8'h77);
    check("udf_set", udf_err, 1);
    check("udf_empty", empty, 1);
    check("udf_fill", fill_level, 0);

    // Soft reset flushes errors and data_out
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("srst_ovf", ovf_err, 0);
    check("srst_udf", udf_err, 0);
    check("srst_dout", data_out, 0);
    check("srst_fill", fill_level, 0);
    check("srst_empty", empty, 1);

    // Pointer wrap: 20 streaming write/read cycles
    wr(8'h00, 1'b0);
    for (int i = 1; i < 20; i++) begin
      write_en = 1'b1; read_en = 1'b1; data_in = 8'(i);
      tick();
      check("wrap_dout", data_out, 8'(i - 1));
      check("wrap_full", full, 0);
      check("wrap_fill", fill_level, 1);
    end
    write_en = 1'b0; read_en = 1'b0;
    rd();
    check("wrap_last", data_out, 8'h13);
    check("wrap_empty", empty, 1);

    // Mid-packet async reset
    wr(8'h10, 1'b1);
    wr(8'hB1, 1'b0);
    wr(8'hB2, 1'b0);
    wr(8'hB3, 1'b0);
    rd(); rd(); rd();
    check("mid_dout", data_out, 8'hB2);
    check("mid_busy", pkt_busy, 1);
    #3;
    resetn = 1'b0;
    #1;
    check("async_dout", data_out, 0);
    check("async_fill", fill_level, 0);
    check("async_empty", empty, 1);
    check("async_busy", pkt_busy, 0);
    #2;
    resetn = 1'b1;
    #2;
    wr(8'h04, 1'b1);
    wr(8'hC1, 1'b0);
    wr(8'hC2, 1'b0);
    rd();
    check("hdr2_dout", data_out, 8'h04);
    check("hdr2_busy", pkt_busy, 1);
    rd();
    check("hdr2_b1_done", pkt_done, 0);
    check("hdr2_b1_busy", pkt_busy, 1);
    rd();
    check("hdr2_par_dout", data_out, 8'hC2);
    check("hdr2_par_done", pkt_done, 1);
    check("hdr2_par_busy", pkt_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised packet FIFO for the router output channels; successor to the fixed 8x16 channel FIFO. Each stored word carries an extra header-tag bit written from lfd_state. A read-side down counter tracks the remaining bytes of the packet being drained. Adds almost-full/almost-empty flags, an occupancy count, a packet-done pulse and sticky overflow/underflow errors; the data output holds its value instead of tri-stating.

Parameters:
DATA_W, 8, data byte width; stored word is DATA_W+1 bits (header tag in MSB)
DEPTH, 16, entries; power of two, >=4
AW, $clog2(DEPTH), pointer index width; pointers are AW+1 bits
LEN_LSB, 2, LSB of the payload-length field in a header byte; field is data[DATA_W-1:LEN_LSB]
AF_LEVEL, DEPTH-2, almost_full asserts when fill_level >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when fill_level <= AE_LEVEL

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous flush, active high (channel timeout)
write_en  in  1  write request
read_en  in  1  read request
lfd_state  in  1  current write is a header byte; stored as tag
data_in  in  DATA_W  write data
data_out  out  DATA_W  registered read data
empty  out  1  no entries
full  out  1  DEPTH entries
almost_full  out  1  see AF_LEVEL
almost_empty  out  1  see AE_LEVEL
fill_level  out  AW+1  entry count, 0..DEPTH
pkt_busy  out  1  remaining-byte counter nonzero
pkt_done  out  1  one-cycle pulse: last byte of packet (parity) read
ovf_err  out  1  sticky: write attempted while full
udf_err  out  1  sticky: read attempted while empty

Behaviour:
- Reset (resetn low, async) and soft_reset (sync, wins over all other inputs): wr_ptr=rd_ptr=0, fill_level=0, rem_cnt=0, data_out=0, pkt_done=0, ovf_err=udf_err=0. Hence empty=1, full=0, almost_empty=1, almost_full=0, pkt_busy=0. Memory contents need not be cleared; no output may depend on stale contents.
- empty = (wr_ptr == rd_ptr); full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]). Pointers wrap modulo 2*DEPTH.
- fill_level, almost_* , pkt_busy: registered counters/flags, all consistent with pointers after the same edge; empty/full combinational from pointers.
- Write accepted iff write_en && !full (flags as sampled before the edge): mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr++.
- Read accepted iff read_en && !empty: data_out <= mem[rd_ptr][DATA_W-1:0] at that edge (1-cycle latency); rd_ptr++. Otherwise data_out holds its value.
- Simultaneous accepted read and write: fill_level unchanged. When full, write rejected, read proceeds. When empty, read rejected, write proceeds (no write-through).
- Remaining counter rem_cnt (DATA_W-LEN_LSB+1 bits): on accepted read of a tagged word, rem_cnt <= len+1 (payload plus parity). On accepted read of an untagged word with rem_cnt!=0, rem_cnt--. pkt_done pulses on the edge where an untagged read takes rem_cnt from 1 to 0; otherwise 0.
- Header with len=0: rem_cnt=1; next byte read (parity) pulses pkt_done.
- Header read while rem_cnt!=0 (truncated packet): reload, no pkt_done.
- ovf_err sets on write_en && full; udf_err on read_en && empty; clear only by reset/soft_reset.
- Reset asserted mid-packet: all state cleared immediately; first read after must be a header for counter to resume.

Test Plan:
- Reset then write header 0x0C (len=3, tag=1), 0xA1,0xA2,0xA3, parity 0x5E; read 5 -> data_out A... sequence 0C,A1,A2,A3,5E one cycle after each read; rem_cnt 4,3,2,1,0; pkt_done high exactly with 5E; pkt_busy low after.
- Write 16 bytes (DEPTH=16) -> full=1, fill_level=16, almost_full from level 14; 17th write -> ignored, ovf_err=1; read all 16 -> data intact, empty=1.
- At fill_level=16 assert read_en and write_en together -> read completes, write dropped, fill_level=15; at fill_level=8 both -> fill_level stays 8, pointers each +1.
- Read on empty -> data_out unchanged, udf_err=1, pointers unchanged; soft_reset one cycle -> errors cleared, fill_level=0, data_out=0.
- Wrap: 20 write/read cycles of 0x00..0x13 with depth 16 -> in-order output, full never asserted falsely, empty after last read.
- Mid-packet (after header 0x10 and 2 bytes read) pull resetn low asynchronously between edges -> outputs reset immediately without clock; next header 0x04 -> rem_cnt=2 on read.
